// File: rtl/belt_motor_pkg.sv
// belt_motor_pkg
//   Shared definitions for the conveyor belt H-bridge driver:
//   - state_e    : FSM state encoding (also driven out on state_o for LEDs)
//   - PIN_*      : 2-bit {in_a, in_b} H-bridge pin patterns
//   - map_pins() : applies the per-channel polarity swap for mirror-mounted motors
package belt_motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAMP_UP = 3'd1,
    ST_RUN     = 3'd2,
    ST_RAMP_DN = 3'd3,
    ST_BRAKE   = 3'd4
  } state_e;

  // Patterns are {in_a, in_b}.
  localparam logic [1:0] PIN_COAST = 2'b00;
  localparam logic [1:0] PIN_FWD   = 2'b01;
  localparam logic [1:0] PIN_REV   = 2'b10;
  localparam logic [1:0] PIN_BRAKE = 2'b11;

  // A mirror-mounted motor turns the same way as its neighbour when a/b are swapped.
  function automatic logic [1:0] map_pins(input logic [1:0] pat, input logic inv);
    if (inv) begin
      map_pins = {pat[0], pat[1]};
    end else begin
      map_pins = pat;
    end
  endfunction

endpackage

// File: rtl/belt_motor_ctrl_if.sv
// belt_motor_ctrl_if
//   Command and pin bundle between the belt controller (master) and the
//   motor driver (slave).
//   Commands : on_belt, off_belt, estop, dir, duty[PWM_W]
//   Pins     : in_a/in_b/en[N_CH], running, state_o[3]
interface belt_motor_ctrl_if #(
  parameter int N_CH  = 2,
  parameter int PWM_W = 16
);
  logic             on_belt;
  logic             off_belt;
  logic             estop;
  logic             dir;
  logic [PWM_W-1:0] duty;
  logic [N_CH-1:0]  in_a;
  logic [N_CH-1:0]  in_b;
  logic [N_CH-1:0]  en;
  logic             running;
  logic [2:0]       state_o;

  modport master (
    output on_belt, off_belt, estop, dir, duty,
    input  in_a, in_b, en, running, state_o
  );

  modport slave (
    input  on_belt, off_belt, estop, dir, duty,
    output in_a, in_b, en, running, state_o
  );
endinterface

// File: rtl/belt_motor_ctrl_pwm_gen.sv
// pwm_gen
//   Free-running PWM counter 0..PWM_PERIOD-1 with a shadowed duty compare.
//   clk, rst : clock, synchronous active-high reset
//   duty_in  : requested duty in clk cycles per period
//   wrap     : high on the last count of each period
//   pwm_out  : combinational (cnt < shadowed duty)
module pwm_gen #(
  parameter int PWM_W      = 16,
  parameter int PWM_PERIOD = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty_in,
  output logic             wrap,
  output logic             pwm_out
);
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(PWM_PERIOD - 1);
  localparam logic [PWM_W-1:0] CNT_ONE  = PWM_W'(1);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] shadow_q, shadow_d;

  // Counter wrap and shadow load: duty only changes at a period boundary so no
  // period ever sees a truncated or doubled pulse.
  always_comb begin
    wrap = (cnt_q == CNT_LAST);
    if (wrap) begin
      cnt_d    = '0;
      shadow_d = duty_in;
    end else begin
      cnt_d    = cnt_q + CNT_ONE;
      shadow_d = shadow_q;
    end
    // shadow >= period keeps this high all period; shadow 0 keeps it low.
    pwm_out = (cnt_q < shadow_q);
  end

  // Counter and shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: rtl/belt_motor_ctrl.sv
// belt_motor_ctrl
//   N-channel H-bridge PWM driver with soft start/stop ramps, runtime duty and
//   direction, brake dead-time on reversal and emergency stop.
//   clk, rst : clock, synchronous active-high reset
//   bus      : belt_motor_ctrl_if.slave (commands in, pins/status out)
//   All pin outputs are registered from next-state values, so a sampled input
//   shows on the pins at the following edge.
module belt_motor_ctrl
  import belt_motor_pkg::*;
#(
  parameter int              N_CH       = 2,
  parameter int              PWM_W      = 16,
  parameter int              PWM_PERIOD = 50000,
  parameter int              RAMP_CYC   = 500,
  parameter int              RAMP_STEP  = 50,
  parameter int              DEAD_CYC   = 50000,
  parameter logic [N_CH-1:0] INV_MASK   = 2'b01
) (
  input logic               clk,
  input logic               rst,
  belt_motor_ctrl_if.slave  bus
);
  localparam int RAMP_W = $clog2(RAMP_CYC + 1);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam logic [PWM_W-1:0]  PERIOD_V  = PWM_W'(PWM_PERIOD);
  localparam logic [PWM_W-1:0]  STEP_V    = PWM_W'(RAMP_STEP);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYC - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

  state_e            state_q, state_d;
  logic [PWM_W-1:0]  duty_cur_q, duty_cur_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              dir_q, dir_d;
  logic              rev_pend_q, rev_pend_d;
  logic [N_CH-1:0]   in_a_q, in_a_d, in_b_q, in_b_d, en_q, en_d;
  logic              running_q, running_d;

  logic [PWM_W-1:0]  tgt, step_up_v, step_dn_v, slew_v;
  logic [PWM_W:0]    up_sum;
  logic              ramp_tick;
  logic [1:0]        pat, ch_pins;
  logic              en_bit;
  logic              pwm_out;
  // Period boundary from the PWM block; the FSM only needs the compare.
  logic              pwm_wrap_unused;

  pwm_gen #(
    .PWM_W      (PWM_W),
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty_in (duty_cur_q),
    .wrap    (pwm_wrap_unused),
    .pwm_out (pwm_out)
  );

  // Ramp arithmetic: target saturation and the three step flavours.
  always_comb begin
    ramp_tick = (ramp_q == RAMP_LAST);
    tgt       = (bus.duty > PERIOD_V) ? PERIOD_V : bus.duty;
    // One extra bit so a step near the top of the counter range cannot wrap.
    up_sum    = {1'b0, duty_cur_q} + {1'b0, STEP_V};
    step_up_v = (up_sum > {1'b0, tgt}) ? tgt : up_sum[PWM_W-1:0];
    step_dn_v = (duty_cur_q > STEP_V) ? (duty_cur_q - STEP_V) : '0;
    if (duty_cur_q < tgt) begin
      slew_v = step_up_v;
    end else if ((duty_cur_q - tgt) > STEP_V) begin
      slew_v = duty_cur_q - STEP_V;
    end else begin
      slew_v = tgt;
    end
  end

  // FSM next state, duty ramp, dead-time and direction bookkeeping.
  always_comb begin
    state_d    = state_q;
    duty_cur_d = duty_cur_q;
    dir_d      = dir_q;
    rev_pend_d = rev_pend_q;
    dead_d     = dead_q;
    ramp_d     = ramp_tick ? '0 : (ramp_q + RAMP_ONE);

    if (bus.estop) begin
      // Dead count stays cleared while estop is held, so it runs after release.
      state_d    = ST_BRAKE;
      duty_cur_d = '0;
      rev_pend_d = 1'b0;
      dead_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.on_belt && !bus.off_belt) begin
            state_d = ST_RAMP_UP;
            dir_d   = bus.dir;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP_UP: begin
          if (bus.off_belt) begin
            state_d    = ST_RAMP_DN;
            rev_pend_d = 1'b0;
          end else if (duty_cur_q == tgt) begin
            state_d = ST_RUN;
          end else if (ramp_tick) begin
            duty_cur_d = step_up_v;
          end else begin
            duty_cur_d = duty_cur_q;
          end
        end
        ST_RUN: begin
          if (bus.off_belt) begin
            state_d    = ST_RAMP_DN;
            rev_pend_d = 1'b0;
          end else if (bus.dir != dir_q) begin
            state_d    = ST_RAMP_DN;
            rev_pend_d = 1'b1;
          end else if (ramp_tick) begin
            duty_cur_d = slew_v;
          end else begin
            duty_cur_d = duty_cur_q;
          end
        end
        ST_RAMP_DN: begin
          if (duty_cur_q == '0) begin
            state_d = ST_BRAKE;
            dead_d  = '0;
          end else if (ramp_tick) begin
            duty_cur_d = step_dn_v;
          end else begin
            duty_cur_d = duty_cur_q;
          end
        end
        ST_BRAKE: begin
          if (dead_q == DEAD_LAST) begin
            if (rev_pend_q) begin
              state_d    = ST_RAMP_UP;
              dir_d      = bus.dir;
              rev_pend_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dead_d = dead_q + DEAD_ONE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          duty_cur_d = '0;
          rev_pend_d = 1'b0;
        end
      endcase
    end

    // Every ramp-up starts a full step interval from its entry edge.
    if ((state_d == ST_RAMP_UP) && (state_q != ST_RAMP_UP)) begin
      ramp_d = '0;
    end else begin
      ramp_d = ramp_d;
    end
  end

  // Pin patterns from the next state, then per-channel polarity swap.
  always_comb begin
    pat       = PIN_COAST;
    en_bit    = 1'b0;
    running_d = 1'b0;
    in_a_d    = '0;
    in_b_d    = '0;
    en_d      = '0;
    case (state_d)
      ST_RAMP_UP, ST_RUN: begin
        pat       = dir_d ? PIN_REV : PIN_FWD;
        en_bit    = pwm_out;
        running_d = 1'b1;
      end
      ST_RAMP_DN: begin
        pat    = dir_d ? PIN_REV : PIN_FWD;
        en_bit = pwm_out;
      end
      ST_BRAKE: begin
        pat    = PIN_BRAKE;
        en_bit = 1'b1;
      end
      default: begin
        pat    = PIN_COAST;
        en_bit = 1'b0;
      end
    endcase
    for (int i = 0; i < N_CH; i++) begin
      ch_pins   = map_pins(pat, INV_MASK[i]);
      in_a_d[i] = ch_pins[1];
      in_b_d[i] = ch_pins[0];
      en_d[i]   = en_bit;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_cur_q <= '0;
      ramp_q     <= '0;
      dead_q     <= '0;
      dir_q      <= 1'b0;
      rev_pend_q <= 1'b0;
      in_a_q     <= '0;
      in_b_q     <= '0;
      en_q       <= '0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_cur_q <= duty_cur_d;
      ramp_q     <= ramp_d;
      dead_q     <= dead_d;
      dir_q      <= dir_d;
      rev_pend_q <= rev_pend_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      en_q       <= en_d;
      running_q  <= running_d;
    end
  end

  assign bus.in_a    = in_a_q;
  assign bus.in_b    = in_b_q;
  assign bus.en      = en_q;
  assign bus.running = running_q;
  assign bus.state_o = state_q;
endmodule
